// File: rtl/pic_pkg.sv
// Shared encodings for the pic_control_n control block: init/ack FSM states,
// OCW2 command codes and a compile-time log2 helper.
package pic_pkg;

  typedef enum logic [1:0] {
    CMD_READY = 2'd0,
    CMD_ICW2  = 2'd1,
    CMD_ICW3  = 2'd2,
    CMD_ICW4  = 2'd3
  } cmd_state_t;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK_1    = 2'd1,
    ACK_2    = 2'd2
  } ack_state_t;

  typedef enum logic [2:0] {
    OCW2_ROT_CLR    = 3'b000,
    OCW2_NS_EOI     = 3'b001,
    OCW2_NOP        = 3'b010,
    OCW2_SP_EOI     = 3'b011,
    OCW2_ROT_SET    = 3'b100,
    OCW2_ROT_NS_EOI = 3'b101,
    OCW2_SET_PRI    = 3'b110,
    OCW2_ROT_SP_EOI = 3'b111
  } ocw2_cmd_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating find-first: returns the set bit of vec_i nearest above lowest_i,
// wrapping, i.e. level (lowest+1) mod NUM_IRQ has the highest priority.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter  int NUM_IRQ = 8,
  localparam int ID_W    = log2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] vec_i,
  input  logic [ID_W-1:0]    lowest_i,
  output logic [ID_W-1:0]    id_o,
  output logic               found_o
);

  logic [ID_W-1:0] idx;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    id_o    = '0;
    found_o = 1'b0;
    idx     = '0;
    // Scan from lowest priority to highest so the last hit is the winner.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      idx = lowest_i + ID_W'(i + 1);
      if (vec_i[idx]) begin
        id_o    = idx;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_control_n.sv
// 8259-style control logic: ICW init sequence, OCW decode, ISR, rotating
// priority and the two-pulse INTA sequence for NUM_IRQ request lines.
module pic_control_n
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         internal_data_bus,
  input  logic               write_ICW1,
  input  logic               write_ICW2_4,
  input  logic               write_OCW1,
  input  logic               write_OCW2,
  input  logic               write_OCW3,
  input  logic               int_ack,
  input  logic [NUM_IRQ-1:0] irr,
  output logic               INT,
  output logic [7:0]         vector_out,
  output logic               vector_valid,
  output logic [NUM_IRQ-1:0] clear_IRR,
  output logic [NUM_IRQ-1:0] isr,
  output logic [NUM_IRQ-1:0] int_mask,
  output logic               level_edge_triggered,
  output logic               read_reg_isr_or_irr,
  output logic [7:0]         cascade_config,
  output logic               init_done
);

  localparam int ID_W = log2(NUM_IRQ);

  cmd_state_t         cmd_q;
  ack_state_t         ack_q;
  logic               ltim_q, sngl_q, ic4_q, aeoi_q;
  logic               rotate_q, rotate_d;
  logic [7-ID_W:0]    base_q;
  logic [ID_W-1:0]    lowest_q, lowest_d, ack_id_q;
  logic               spurious_q;
  logic [NUM_IRQ-1:0] isr_q, isr_d, mask_q, clear_q;
  logic               int_q, vvalid_q, rd_isr_q, init_done_q;
  logic [7:0]         vector_q, cascade_q;

  logic [ID_W-1:0]    cand_id, isr_hi_id, ocw2_lvl;
  logic               cand_found, isr_found, cand_above, int_next;
  logic               ack_first, ack_second, ocw2_ok;
  logic [NUM_IRQ-1:0] cand_onehot, isr_clr;
  ocw2_cmd_t          ocw2_cmd;

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_irr_res (
    .vec_i    (irr & ~mask_q),
    .lowest_i (lowest_q),
    .id_o     (cand_id),
    .found_o  (cand_found)
  );

  pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
    .vec_i    (isr_q),
    .lowest_i (lowest_q),
    .id_o     (isr_hi_id),
    .found_o  (isr_found)
  );

  // Rank 0 is the highest priority under the current rotation.
  function automatic logic [ID_W-1:0] rank(input logic [ID_W-1:0] id,
                                           input logic [ID_W-1:0] lowest);
    return id - lowest - ID_W'(1);
  endfunction

  assign ack_first  = int_ack && init_done_q && (ack_q == ACK_IDLE);
  assign ack_second = int_ack && init_done_q && (ack_q == ACK_1);
  assign ocw2_ok    = write_OCW2 && init_done_q;
  assign ocw2_cmd   = ocw2_cmd_t'(internal_data_bus[7:5]);
  assign ocw2_lvl   = internal_data_bus[ID_W-1:0];

  assign cand_above = cand_found &&
                      (!isr_found || (rank(cand_id, lowest_q) < rank(isr_hi_id, lowest_q)));
  assign int_next   = init_done_q && cand_above &&
                      (((ack_q == ACK_IDLE) && !ack_first) || (ack_q == ACK_2));

  always_comb begin
    cand_onehot          = '0;
    cand_onehot[cand_id] = cand_found;
    isr_clr              = '0;
    lowest_d             = lowest_q;
    rotate_d             = rotate_q;
    if (ack_second && aeoi_q && !spurious_q) begin
      isr_clr[ack_id_q] = 1'b1;
      if (rotate_q) lowest_d = ack_id_q;
    end
    // OCW2 rotation is applied last so it overrides the auto-EOI rotate.
    if (ocw2_ok) begin
      unique case (ocw2_cmd)
        OCW2_NS_EOI:     if (isr_found) isr_clr[isr_hi_id] = 1'b1;
        OCW2_SP_EOI:     isr_clr[ocw2_lvl] = 1'b1;
        OCW2_ROT_NS_EOI: if (isr_found) begin
                           isr_clr[isr_hi_id] = 1'b1;
                           lowest_d           = isr_hi_id;
                         end
        OCW2_ROT_SP_EOI: begin
                           isr_clr[ocw2_lvl] = 1'b1;
                           lowest_d          = ocw2_lvl;
                         end
        OCW2_ROT_SET:    rotate_d = 1'b1;
        OCW2_ROT_CLR:    rotate_d = 1'b0;
        OCW2_SET_PRI:    lowest_d = ocw2_lvl;
        OCW2_NOP:        ;
      endcase
    end
    isr_d = (isr_q & ~isr_clr) | (ack_first ? cand_onehot : '0);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q       <= CMD_READY;
      ack_q       <= ACK_IDLE;
      ltim_q      <= 1'b0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      aeoi_q      <= 1'b0;
      rotate_q    <= 1'b0;
      base_q      <= '0;
      lowest_q    <= ID_W'(NUM_IRQ - 1);
      ack_id_q    <= '0;
      spurious_q  <= 1'b0;
      isr_q       <= '0;
      mask_q      <= '1;
      clear_q     <= '0;
      int_q       <= 1'b0;
      vvalid_q    <= 1'b0;
      vector_q    <= '0;
      cascade_q   <= '0;
      rd_isr_q    <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      clear_q  <= '0;
      vvalid_q <= 1'b0;
      if (write_ICW1) begin
        cmd_q       <= CMD_ICW2;
        ltim_q      <= internal_data_bus[3];
        sngl_q      <= internal_data_bus[1];
        ic4_q       <= internal_data_bus[0];
        isr_q       <= '0;
        cascade_q   <= '0;
        aeoi_q      <= 1'b0;
        rotate_q    <= 1'b0;
        mask_q      <= '1;
        lowest_q    <= ID_W'(NUM_IRQ - 1);
        rd_isr_q    <= 1'b0;
        ack_q       <= ACK_IDLE;
        int_q       <= 1'b0;
        init_done_q <= 1'b0;
      end else begin
        isr_q    <= isr_d;
        lowest_q <= lowest_d;
        rotate_q <= rotate_d;
        int_q    <= int_next;

        if (write_ICW2_4) begin
          unique case (cmd_q)
            CMD_ICW2: begin
              base_q <= internal_data_bus[7:ID_W];
              if (!sngl_q)    cmd_q <= CMD_ICW3;
              else if (ic4_q) cmd_q <= CMD_ICW4;
              else begin
                cmd_q       <= CMD_READY;
                init_done_q <= 1'b1;
              end
            end
            CMD_ICW3: begin
              cascade_q <= internal_data_bus;
              if (ic4_q) cmd_q <= CMD_ICW4;
              else begin
                cmd_q       <= CMD_READY;
                init_done_q <= 1'b1;
              end
            end
            CMD_ICW4: begin
              aeoi_q      <= internal_data_bus[1];
              cmd_q       <= CMD_READY;
              init_done_q <= 1'b1;
            end
            CMD_READY: ;
          endcase
        end

        if (write_OCW1 && init_done_q) mask_q <= NUM_IRQ'(internal_data_bus);
        if (write_OCW3 && init_done_q) begin
          if (internal_data_bus[1:0] == 2'b10) rd_isr_q <= 1'b0;
          if (internal_data_bus[1:0] == 2'b11) rd_isr_q <= 1'b1;
        end

        unique case (ack_q)
          ACK_IDLE: if (ack_first) begin
            ack_id_q   <= cand_found ? cand_id : ID_W'(NUM_IRQ - 1);
            spurious_q <= !cand_found;
            clear_q    <= cand_onehot;
            ack_q      <= ACK_1;
          end
          ACK_1: if (ack_second) begin
            vector_q <= {base_q, ack_id_q};
            vvalid_q <= 1'b1;
            ack_q    <= ACK_2;
          end
          ACK_2:   ack_q <= ACK_IDLE;
          default: ack_q <= ACK_IDLE;
        endcase
      end
    end
  end

  assign INT                  = int_q;
  assign vector_out           = vector_q;
  assign vector_valid         = vvalid_q;
  assign clear_IRR            = clear_q;
  assign isr                  = isr_q;
  assign int_mask             = mask_q;
  assign level_edge_triggered = ltim_q;
  assign read_reg_isr_or_irr  = rd_isr_q;
  assign cascade_config       = cascade_q;
  assign init_done            = init_done_q;

endmodule

// File: tb/tb_pic_control_n.sv
// Directed bench for pic_control_n (NUM_IRQ=8): init, INTA, EOI, rotation,
// nesting, spurious and ICW1-abort scenarios with hand-computed expectations.
module tb_pic_control_n;

  localparam logic [4:0] W_ICW1  = 5'b10000;
  localparam logic [4:0] W_ICW24 = 5'b01000;
  localparam logic [4:0] W_OCW1  = 5'b00100;
  localparam logic [4:0] W_OCW2  = 5'b00010;
  localparam logic [4:0] W_OCW3  = 5'b00001;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] internal_data_bus;
  logic       write_ICW1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3;
  logic       int_ack;
  logic [7:0] irr;
  logic       INT, vector_valid, level_edge_triggered, read_reg_isr_or_irr, init_done;
  logic [7:0] vector_out, clear_IRR, isr, int_mask, cascade_config;

  int checks   = 0;
  int failures = 0;

  pic_control_n #(.NUM_IRQ(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .internal_data_bus    (internal_data_bus),
    .write_ICW1           (write_ICW1),
    .write_ICW2_4         (write_ICW2_4),
    .write_OCW1           (write_OCW1),
    .write_OCW2           (write_OCW2),
    .write_OCW3           (write_OCW3),
    .int_ack              (int_ack),
    .irr                  (irr),
    .INT                  (INT),
    .vector_out           (vector_out),
    .vector_valid         (vector_valid),
    .clear_IRR            (clear_IRR),
    .isr                  (isr),
    .int_mask             (int_mask),
    .level_edge_triggered (level_edge_triggered),
    .read_reg_isr_or_irr  (read_reg_isr_or_irr),
    .cascade_config       (cascade_config),
    .init_done            (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] sel, input logic [7:0] d);
    {write_ICW1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3} = sel;
    internal_data_bus = d;
    tick();
    {write_ICW1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3} = '0;
    internal_data_bus = '0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    internal_data_bus = '0;
    {write_ICW1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3} = '0;
    int_ack = 1'b0;
    irr = '0;
    tick(); tick();
    check("rst_int",      INT, 0);
    check("rst_vec",      vector_out, 8'h00);
    check("rst_vvalid",   vector_valid, 0);
    check("rst_clr",      clear_IRR, 8'h00);
    check("rst_isr",      isr, 8'h00);
    check("rst_mask",     int_mask, 8'hFF);
    check("rst_ltim",     level_edge_triggered, 0);
    check("rst_rd",       read_reg_isr_or_irr, 0);
    check("rst_cascade",  cascade_config, 8'h00);
    check("rst_init",     init_done, 0);
    reset = 1'b0;
    tick();

    // Single, ICW4, AEOI=1: IR2 -> vector 0x42, ISR auto-cleared.
    wr(W_ICW1, 8'h13);
    check("icw1_init", init_done, 0);
    wr(W_ICW24, 8'h40);
    wr(W_ICW24, 8'h03);
    check("icw4_init", init_done, 1);
    wr(W_OCW1, 8'h00);
    check("ocw1_mask", int_mask, 8'h00);
    irr = 8'h04; tick();
    check("aeoi_int", INT, 1);
    ack();
    check("aeoi_clr", clear_IRR, 8'h04);
    check("aeoi_isr_set", isr, 8'h04);
    check("aeoi_int_drop", INT, 0);
    irr = 8'h00;
    ack();
    check("aeoi_vvalid", vector_valid, 1);
    check("aeoi_vec", vector_out, 8'h42);
    check("aeoi_isr", isr, 8'h00);
    tick();
    check("aeoi_vvalid_pulse", vector_valid, 0);

    // AEOI=0: IR0 beats IR7, non-specific EOI, then IR7.
    wr(W_ICW1, 8'h13);
    wr(W_ICW24, 8'h40);
    wr(W_ICW24, 8'h01);
    wr(W_OCW1, 8'h00);
    irr = 8'h81; tick();
    check("n_int", INT, 1);
    ack();
    check("n_clr", clear_IRR, 8'h01);
    irr = 8'h80;
    ack();
    check("n_vec0", vector_out, 8'h40);
    check("n_isr0", isr, 8'h01);
    tick();
    check("n_int_blocked", INT, 0);
    wr(W_OCW2, 8'h20);
    check("n_eoi", isr, 8'h00);
    tick();
    check("n_int7", INT, 1);
    ack(); irr = 8'h00; ack();
    check("n_vec7", vector_out, 8'h47);
    check("n_isr7", isr, 8'h80);
    wr(W_OCW2, 8'h20);
    check("n_eoi7", isr, 8'h00);

    // Specific priority: lowest=3 makes IR4 highest.
    wr(W_OCW2, 8'hC3);
    irr = 8'h11; tick();
    check("rot_int", INT, 1);
    ack();
    check("rot_clr", clear_IRR, 8'h10);
    irr = 8'h01;
    ack();
    check("rot_vec", vector_out, 8'h44);
    irr = 8'h00;
    wr(W_OCW2, 8'h20);
    check("rot_eoi", isr, 8'h00);
    wr(W_OCW2, 8'h20);
    check("eoi_empty", isr, 8'h00);
    wr(W_OCW2, 8'hC7);

    // Nesting: ISR[2] in service blocks IR3 but not IR1.
    irr = 8'h04; tick();
    ack(); irr = 8'h00; ack();
    check("nest_isr", isr, 8'h04);
    irr = 8'h08; tick(); tick();
    check("nest_block", INT, 0);
    irr = 8'h02; tick();
    check("nest_int", INT, 1);

    // Request withdrawn as the first INTA arrives: spurious IR7 vector.
    irr = 8'h00; ack();
    check("spur_clr", clear_IRR, 8'h00);
    check("spur_isr1", isr, 8'h04);
    ack();
    check("spur_vec", vector_out, 8'h47);
    check("spur_isr2", isr, 8'h04);
    wr(W_OCW2, 8'h20);
    check("spur_eoi", isr, 8'h00);

    // ICW1 between the two INTA pulses aborts the sequence.
    irr = 8'h08; tick();
    ack();
    check("abort_isr_set", isr, 8'h08);
    irr = 8'h00;
    wr(W_ICW1, 8'h1B);
    check("abort_isr", isr, 8'h00);
    check("abort_mask", int_mask, 8'hFF);
    check("abort_init", init_done, 0);
    check("abort_ltim", level_edge_triggered, 1);
    wr(W_OCW1, 8'h00);
    check("ocw1_ignored", int_mask, 8'hFF);
    ack();
    check("abort_vvalid", vector_valid, 0);
    check("abort_clr", clear_IRR, 8'h00);

    // Cascade path with ICW3, AEOI plus auto-rotate.
    wr(W_ICW1, 8'h11);
    wr(W_ICW24, 8'h40);
    check("icw3_pending", init_done, 0);
    wr(W_ICW24, 8'h5A);
    wr(W_ICW24, 8'h02);
    check("casc_cfg", cascade_config, 8'h5A);
    check("casc_init", init_done, 1);
    wr(W_OCW3, 8'h0B);
    check("ocw3_set", read_reg_isr_or_irr, 1);
    wr(W_OCW3, 8'h0A);
    check("ocw3_clr", read_reg_isr_or_irr, 0);
    wr(W_OCW1, 8'h00);
    wr(W_OCW2, 8'h80);
    irr = 8'h04; tick();
    ack(); irr = 8'h00; ack();
    check("arot_vec2", vector_out, 8'h42);
    check("arot_isr", isr, 8'h00);
    irr = 8'h09; tick();
    check("arot_int", INT, 1);
    ack();
    check("arot_clr", clear_IRR, 8'h08);
    irr = 8'h01;
    ack();
    check("arot_vec3", vector_out, 8'h43);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
